// File: rtl/pb_intc.sv
// pb_intc: merges eight edge-detected peripheral interrupts into one Picoblaze interrupt with ack/EOI handshake.
// Optional round-robin arbitration is built when PB_INTC_ROUND_ROBIN_EN is defined.
module pb_intc #(
  parameter logic [7:0] INTC_BASE_ADDRESS = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] data_in,
  input  logic       read_strobe,
  input  logic       write_strobe,
  input  logic [7:0] irq_in,
  input  logic       interrupt_ack,
  output logic [7:0] data_out,
  output logic       interrupt
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t     state, state_nxt;
  logic [7:0] irq_q, pending, pending_nxt, enable;
  logic       gie;
  logic [2:0] idx, idx_nxt;
  logic       ack_clr;
  logic [7:0] elig, rise, w1c, ack_mask, rd_dat;
  logic [2:0] fix_win, win;
  logic       rr_mode;
  logic       unused;

  // Reads are side-effect free, so the strobe is not needed.
  assign unused = read_strobe;

  logic sel, wr_pend, wr_en, wr_ctl, wr_eoi;
  assign sel     = (port_id[7:2] == INTC_BASE_ADDRESS[7:2]);
  assign wr_pend = write_strobe && sel && (port_id[1:0] == 2'd0);
  assign wr_en   = write_strobe && sel && (port_id[1:0] == 2'd1);
  assign wr_ctl  = write_strobe && sel && (port_id[1:0] == 2'd2);
  assign wr_eoi  = write_strobe && sel && (port_id[1:0] == 2'd3);

  assign rise     = irq_in & ~irq_q;
  assign w1c      = wr_pend ? data_in : 8'h00;
  assign ack_mask = ack_clr ? (8'h01 << idx) : 8'h00;
  // A new edge beats W1C, but an acknowledge beats a new edge.
  assign pending_nxt = ((pending & ~w1c) | rise) & ~ack_mask;
  assign elig = pending & enable & {8{gie}};

  always_comb begin
    fix_win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (elig[i]) fix_win = 3'(i);
    end
  end

`ifdef PB_INTC_ROUND_ROBIN_EN
  logic       rr;
  logic [2:0] last_served, rr_win, cand;
  logic       found;

  always_comb begin
    rr_win = 3'd0;
    found  = 1'b0;
    cand   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = last_served + 3'(k) + 3'd1;
      if (!found && elig[cand]) begin
        rr_win = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr          <= 1'b0;
      last_served <= 3'd7;
    end else begin
      if (wr_ctl) rr <= data_in[1];
      if (state == S_ASSERT && interrupt_ack) last_served <= idx;
    end
  end

  assign rr_mode = rr;
  assign win     = rr ? rr_win : fix_win;
`else
  assign rr_mode = 1'b0;
  assign win     = fix_win;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ack_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (|elig) begin
          state_nxt = S_ASSERT;
          idx_nxt   = win;
        end
      end
      S_ASSERT: begin
        if (interrupt_ack) begin
          state_nxt = S_SERVICE;
          ack_clr   = 1'b1;
        end else if (!gie || !enable[idx]) begin
          state_nxt = S_IDLE;
          idx_nxt   = 3'd0;
        end
      end
      S_SERVICE: begin
        if (wr_eoi) begin
          state_nxt = S_IDLE;
          idx_nxt   = 3'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  always_comb begin
    rd_dat = 8'h00;
    if (sel) begin
      case (port_id[1:0])
        2'd0:    rd_dat = pending;
        2'd1:    rd_dat = enable;
        2'd2:    rd_dat = {6'b0, rr_mode, gie};
        default: rd_dat = {(state != S_IDLE), 4'b0, idx};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q     <= 8'h00;
      pending   <= 8'h00;
      enable    <= 8'h00;
      gie       <= 1'b0;
      state     <= S_IDLE;
      idx       <= 3'd0;
      interrupt <= 1'b0;
      data_out  <= 8'h00;
    end else begin
      irq_q     <= irq_in;
      pending   <= pending_nxt;
      if (wr_en)  enable <= data_in;
      if (wr_ctl) gie    <= data_in[0];
      state     <= state_nxt;
      idx       <= idx_nxt;
      interrupt <= (state_nxt == S_ASSERT);
      data_out  <= rd_dat;
    end
  end

endmodule

// File: tb/tb_pb_intc.sv
// Directed bench for pb_intc: reset, single source, priority, GIE drop, service-time edges, W1C, RR.
module tb_pb_intc;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic       read_strobe = 1'b0;
  logic       write_strobe = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic       interrupt_ack = 1'b0;
  logic [7:0] data_out;
  logic       interrupt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pb_intc #(.INTC_BASE_ADDRESS(BASE)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
    .read_strobe(read_strobe), .write_strobe(write_strobe), .irq_in(irq_in),
    .interrupt_ack(interrupt_ack), .data_out(data_out), .interrupt(interrupt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [7:0] val);
    port_id = BASE + {6'b0, off};
    data_in = val;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    port_id = 8'h00;
  endtask

  task automatic rd_reg(input logic [1:0] off, output logic [7:0] val);
    port_id = BASE + {6'b0, off};
    read_strobe = 1'b1;
    tick();
    val = data_out;
    read_strobe = 1'b0;
    port_id = 8'h00;
  endtask

  task automatic pulse(input int n);
    irq_in[n] = 1'b1;
    tick();
    irq_in[n] = 1'b0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b0;
    tick();
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL reset_int got %b want 0", interrupt); else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'h00) $display("FAIL reset_dout got %h want 00", data_out); else pass_cnt++;
    reset = 1'b1;
    tick();
    // Out-of-window reads return zero even when the addressed-looking data is nonzero.
    wr_reg(2'd1, 8'hFF);
    port_id = 8'h14;
    tick();
    total_cnt++;
    if (data_out !== 8'h00) $display("FAIL window got %h want 00", data_out); else pass_cnt++;
    port_id = 8'h00;
    // Reset in the middle of ASSERT.
    wr_reg(2'd1, 8'h01);
    wr_reg(2'd2, 8'h01);
    pulse(0);
    tick();
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL pre_reset_int got %b want 1", interrupt); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL mid_reset_int got %b want 0", interrupt); else pass_cnt++;
    tick();
    reset = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      rd_reg(2'(r), v);
      total_cnt++;
      if (v !== 8'h00) $display("FAIL reset_reg%0d got %h want 00", r, v); else pass_cnt++;
    end
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL post_reset_int got %b want 0", interrupt); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [7:0] v;
    wr_reg(2'd1, 8'h04);
    wr_reg(2'd2, 8'h01);
    pulse(2);
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL single_lat1 got %b want 0", interrupt); else pass_cnt++;
    tick();
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL single_lat2 got %b want 1", interrupt); else pass_cnt++;
    rd_reg(2'd0, v);
    total_cnt++;
    if (v !== 8'h04) $display("FAIL single_pend got %h want 04", v); else pass_cnt++;
    rd_reg(2'd3, v);
    total_cnt++;
    if (v !== 8'h82) $display("FAIL single_vec_assert got %h want 82", v); else pass_cnt++;
    ack();
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL single_ack_int got %b want 0", interrupt); else pass_cnt++;
    rd_reg(2'd0, v);
    total_cnt++;
    if (v !== 8'h00) $display("FAIL single_pend_ack got %h want 00", v); else pass_cnt++;
    rd_reg(2'd3, v);
    total_cnt++;
    if (v !== 8'h82) $display("FAIL single_vec_srv got %h want 82", v); else pass_cnt++;
    wr_reg(2'd3, 8'h00);
    rd_reg(2'd3, v);
    total_cnt++;
    if (v !== 8'h00) $display("FAIL single_vec_eoi got %h want 00", v); else pass_cnt++;
  endtask

  task automatic test_fixed_priority();
    logic [7:0] v;
    wr_reg(2'd1, 8'hFF);
    irq_in = 8'h22;
    tick();
    irq_in = 8'h00;
    tick();
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL prio_int got %b want 1", interrupt); else pass_cnt++;
    rd_reg(2'd3, v);
    total_cnt++;
    if (v !== 8'h81) $display("FAIL prio_vec1 got %h want 81", v); else pass_cnt++;
    ack();
    rd_reg(2'd0, v);
    total_cnt++;
    if (v !== 8'h20) $display("FAIL prio_pend got %h want 20", v); else pass_cnt++;
    wr_reg(2'd3, 8'h00);
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL prio_gap got %b want 0", interrupt); else pass_cnt++;
    tick();
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL prio_reassert got %b want 1", interrupt); else pass_cnt++;
    rd_reg(2'd3, v);
    total_cnt++;
    if (v !== 8'h85) $display("FAIL prio_vec5 got %h want 85", v); else pass_cnt++;
    ack();
    wr_reg(2'd3, 8'h00);
  endtask

  task automatic test_gie_drop();
    logic [7:0] v;
    pulse(3);
    tick();
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL gie_int got %b want 1", interrupt); else pass_cnt++;
    wr_reg(2'd2, 8'h00);
    tick();
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL gie_fall got %b want 0", interrupt); else pass_cnt++;
    rd_reg(2'd0, v);
    total_cnt++;
    if (v !== 8'h08) $display("FAIL gie_pend got %h want 08", v); else pass_cnt++;
    rd_reg(2'd3, v);
    total_cnt++;
    if (v !== 8'h00) $display("FAIL gie_vec_idle got %h want 00", v); else pass_cnt++;
    wr_reg(2'd2, 8'h01);
    tick();
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL gie_reassert got %b want 1", interrupt); else pass_cnt++;
    rd_reg(2'd3, v);
    total_cnt++;
    if (v !== 8'h83) $display("FAIL gie_vec got %h want 83", v); else pass_cnt++;
    ack();
    wr_reg(2'd3, 8'h00);
  endtask

  task automatic test_service_edges();
    logic [7:0] v;
    pulse(4);
    tick();
    ack();
    pulse(4);
    tick();
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL srv_int_low got %b want 0", interrupt); else pass_cnt++;
    rd_reg(2'd0, v);
    total_cnt++;
    if (v !== 8'h10) $display("FAIL srv_pend got %h want 10", v); else pass_cnt++;
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL srv_int_hold got %b want 0", interrupt); else pass_cnt++;
    wr_reg(2'd3, 8'h00);
    tick();
    total_cnt++;
    if (interrupt !== 1'b1) $display("FAIL srv_reassert got %b want 1", interrupt); else pass_cnt++;
    rd_reg(2'd3, v);
    total_cnt++;
    if (v !== 8'h84) $display("FAIL srv_vec got %h want 84", v); else pass_cnt++;
    ack();
    wr_reg(2'd3, 8'h00);
  endtask

  task automatic test_w1c();
    logic [7:0] v;
    wr_reg(2'd1, 8'h00);
    pulse(1);
    pulse(6);
    tick();
    total_cnt++;
    if (interrupt !== 1'b0) $display("FAIL w1c_disabled_int got %b want 0", interrupt); else pass_cnt++;
    rd_reg(2'd0, v);
    total_cnt++;
    if (v !== 8'h42) $display("FAIL w1c_pend_set got %h want 42", v); else pass_cnt++;
    wr_reg(2'd0, 8'h02);
    rd_reg(2'd0, v);
    total_cnt++;
    if (v !== 8'h40) $display("FAIL w1c_clear got %h want 40", v); else pass_cnt++;
    wr_reg(2'd0, 8'hFF);
    // Write all-ones while source 7 rises in the same cycle.
    port_id = BASE;
    data_in = 8'hFF;
    write_strobe = 1'b1;
    irq_in[7] = 1'b1;
    tick();
    write_strobe = 1'b0;
    irq_in[7] = 1'b0;
    port_id = 8'h00;
    rd_reg(2'd0, v);
    total_cnt++;
    if (v !== 8'h80) $display("FAIL w1c_edge_wins got %h want 80", v); else pass_cnt++;
    wr_reg(2'd0, 8'hFF);
  endtask

  task automatic test_round_robin();
    logic [7:0] v;
`ifdef PB_INTC_ROUND_ROBIN_EN
    int exp_seq [4] = '{0, 1, 0, 1};
    int waited;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wr_reg(2'd1, 8'h03);
    wr_reg(2'd2, 8'h03);
    rd_reg(2'd2, v);
    total_cnt++;
    if (v !== 8'h03) $display("FAIL rr_ctl got %h want 03", v); else pass_cnt++;
    irq_in = 8'h03;
    tick();
    irq_in = 8'h00;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (interrupt !== 1'b1 && waited < 10) begin
        tick();
        waited++;
      end
      total_cnt++;
      if (interrupt !== 1'b1) $display("FAIL rr_timeout%0d got %b want 1", k, interrupt); else pass_cnt++;
      rd_reg(2'd3, v);
      total_cnt++;
      if (v !== (8'h80 | 8'(exp_seq[k]))) $display("FAIL rr_vec%0d got %h want %h", k, v, 8'h80 | 8'(exp_seq[k]));
      else pass_cnt++;
      ack();
      pulse(exp_seq[k]);
      wr_reg(2'd3, 8'h00);
    end
`else
    wr_reg(2'd2, 8'h03);
    rd_reg(2'd2, v);
    total_cnt++;
    if (v !== 8'h01) $display("FAIL ctl_rr_absent got %h want 01", v); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_priority();
    test_gie_drop();
    test_service_edges();
    test_w1c();
    test_round_robin();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pb_intc.md
# pb_intc

Port-mapped interrupt controller for the Picoblaze system. It merges up to eight peripheral interrupt lines, such as the GPIO `interrupt` outputs, into the single CPU `interrupt` input. It runs the assert / acknowledge / end-of-interrupt handshake with the CPU and exposes pending, enable, control and vector registers on the `port_id` bus. Its `data_out` is ORed into `in_port` alongside the other peripherals.

## Interface
- `INTC_BASE_ADDRESS`, default 8'h10: base port address. The block decodes four consecutive ports, base+0 to base+3. The base must be 4-aligned.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `port_id`  in  8  CPU port address.
- `data_in`  in  8  CPU `out_port`.
- `read_strobe`  in  1  CPU read strobe. Reads have no side effects.
- `write_strobe`  in  1  CPU write strobe.
- `irq_in`  in  8  peripheral interrupt lines, synchronous to `clk`. Bit n is source n.
- `interrupt_ack`  in  1  CPU interrupt acknowledge.
- `data_out`  out  8  read data. It is 8'h00 whenever `port_id` is outside the block's window.
- `interrupt`  out  1  interrupt request to the CPU.

## Operation
- **Registers (offset from base):**
  - +0 PENDING: R; W1C (writing 1 to a bit clears it).
  - +1 ENABLE: RW; reset 8'h00.
  - +2 CONTROL: RW; bit0 GIE (global interrupt enable), bit1 RR (round-robin mode); bits 7:2 read 0; reset 8'h00.
  - +3 VECTOR: R returns {ACTIVE, 4'b0, IDX[2:0]}; any write to +3 is the EOI (end of interrupt).
- **Edge detect:** `irq_q` registers `irq_in` every cycle. `irq_in & ~irq_q` sets the corresponding PENDING bits. Pending sets even if the source is disabled. A set and a W1C on the same bit in the same cycle leaves the bit set.
- **Eligible sources:** `PENDING & ENABLE`, gated by GIE.
- **Fixed priority (RR=0):** lowest eligible index wins.
- **Round-robin (RR=1):** search starts at `last_served+1` mod 8 and wraps. `last_served` resets to 7, so the first search starts at source 0. `last_served` updates at acknowledge.
- **FSM states:**
  - **IDLE:** `interrupt=0`, ACTIVE=0. If any source is eligible, latch the winner into IDX and go to ASSERT.
  - **ASSERT:** `interrupt=1`, ACTIVE=1.
    - On `interrupt_ack`=1: clear PENDING[IDX], which takes priority over a same-cycle new edge on that bit, and go to SERVICE.
    - If GIE is 0 or ENABLE[IDX] is 0: go to IDLE with PENDING kept and ACTIVE cleared.
    - If both conditions hold in the same cycle, the ack wins.
  - **SERVICE:** `interrupt=0`, ACTIVE=1, IDX held.
    - New edges on any source, including IDX, set PENDING but are not arbitrated.
    - An EOI write goes to IDLE.
    - GIE has no effect in this state.
- **EOI outside SERVICE:** ignored.
- **Register write:** a write takes effect when `write_strobe`=1 and `port_id` matches.
- **Read path:** `data_out` is registered. Each cycle it loads the register addressed by `port_id`, or 8'h00 when `port_id` is outside the window.
- **Reset (asserted):** PENDING, ENABLE and CONTROL are 0; `irq_q`=0; IDX=0; ACTIVE=0; `last_served`=7; FSM in IDLE; `interrupt`=0; `data_out`=8'h00. A reset mid-handshake abandons it with no residue.

## Timing
- `irq_in` rising, first sampled high at edge E: PENDING is set after E. `interrupt` asserts after E+1 if the source is eligible. Latency is 2 clocks.
- `interrupt_ack` sampled high at edge A: `interrupt` is low and PENDING[IDX] is cleared after A.
- EOI write at edge W: IDLE after W. The next `interrupt` can assert after W+1, so there is at least 1 idle cycle between services.
- `data_out` is valid 1 clock after `port_id` settles. This is compatible with the KCPSM6 2-cycle input operation.
- `interrupt` is a direct flop output.

## Configuration
- `PB_INTC_ROUND_ROBIN_EN`:
  - **Defined:** the CONTROL.RR bit and the round-robin arbiter with `last_served` are implemented.
  - **Undefined:** CONTROL bit1 is not stored and reads 0; arbitration is fixed priority only; `last_served` logic is absent.

## Test plan
- **Reset:** assert `reset`=0 mid-ASSERT -> `interrupt`=0, all registers 0, VECTOR=8'h00.
- **Single source:** ENABLE=8'h04, CONTROL=8'h01, pulse `irq_in[2]` -> `interrupt` 2 clocks later; PENDING=8'h04.
  - Ack -> `interrupt`=0, PENDING=8'h00, VECTOR=8'h82.
  - EOI -> VECTOR=8'h00.
- **Fixed priority:** ENABLE=8'hFF, GIE=1, sources 5 and 1 rise in the same cycle -> vector 1 served first, then vector 5 after EOI.
- **Round-robin** (macro defined, CONTROL=8'h03): sources 0 and 1 held pending, re-pulsed after each ack -> vectors alternate 0,1,0,1.
- **GIE drop:** clear GIE while in ASSERT -> `interrupt` falls next clock; PENDING unchanged; re-enable -> `interrupt` reasserts with the same vector.
- **Edges during SERVICE / W1C precedence:**
  - New edge on the IDX source during SERVICE -> PENDING bit set, `interrupt` low until EOI, then reasserts.
  - Write 8'hFF to +0 on the same cycle as a new edge -> that bit stays 1.
